// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, standard or first-word-fall-through read mode, and error pulses.
module fifo_sync_flags #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Reject illegal parameterisations at elaboration.
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be a power of two >= 4");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("fifo_sync_flags: FWFT must be 0 or 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("fifo_sync_flags: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc_c, wr_acc_c;

    // Status flags decode directly from the occupancy register.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions on pre-edge state; a read frees a slot for a write when full.
    always_comb begin
        rd_acc_c = rd_en && !empty;
        wr_acc_c = wr_en && (!full || rd_acc_c);
    end

    // Next-state for pointers, occupancy, read data and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = wr_en && !wr_acc_c;
        underflow_d = rd_en && !rd_acc_c;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_d     = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; not reset, and writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Read-port presentation: head word shown live in FWFT, registered otherwise.
    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        assign rd_valid = !empty;
    end else begin : g_std
        assign data_out = data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: a standard-mode and an FWFT instance share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_fifo_sync_flags;

    localparam int unsigned W = 8;
    localparam int unsigned D = 8;
    localparam int unsigned AF = 6;
    localparam int unsigned AE = 2;

    logic         clk = 1'b0;
    logic         rst_n, wr_en, rd_en;
    logic [W-1:0] data_in;

    logic [W-1:0] s_data, f_data;
    logic         s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic         f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0]   s_count, f_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          checking = 1'b0;

    // Model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ovf, m_udf;

    always #5 clk = ~clk;

    fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_data), .rd_valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_data), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: queue of stored words, updated from pre-edge inputs.
    always @(posedge clk) begin
        bit rd_acc, wr_acc;
        if (!rst_n) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            rd_acc  = rd_en && (q.size() != 0);
            wr_acc  = wr_en && (q.size() < D || rd_acc);
            m_ovf   = wr_en && !wr_acc;
            m_udf   = rd_en && !rd_acc;
            m_valid = rd_acc;
            if (rd_acc) m_data = q.pop_front();
            if (wr_acc) q.push_back(data_in);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            int unsigned n;
            n = q.size();
            chk("s_count", s_count, n);
            chk("s_empty", s_empty, n == 0);
            chk("s_full",  s_full,  n == D);
            chk("s_af",    s_af,    n >= AF);
            chk("s_ae",    s_ae,    n <= AE);
            chk("s_ovf",   s_ovf,   m_ovf);
            chk("s_udf",   s_udf,   m_udf);
            chk("s_valid", s_valid, m_valid);
            chk("s_data",  s_data,  m_data);
            chk("f_count", f_count, n);
            chk("f_empty", f_empty, n == 0);
            chk("f_full",  f_full,  n == D);
            chk("f_af",    f_af,    n >= AF);
            chk("f_ae",    f_ae,    n <= AE);
            chk("f_ovf",   f_ovf,   m_ovf);
            chk("f_udf",   f_udf,   m_udf);
            chk("f_valid", f_valid, n != 0);
            if (n != 0) chk("f_data", f_data, q[0]);
        end
    end

    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit rn);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        rst_n   = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        checking = 1'b1;
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full",  s_full, 0);
        chk("rst_ae",    s_ae, 1);
        chk("rst_af",    s_af, 0);
        chk("rst_data",  s_data, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_fvalid", f_valid, 0);

        // Fill with 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            step(1, W'(8'h10 + i), 0, 1);
            chk("fill_count", s_count, i + 1);
            if (i == 4) chk("af_below", s_af, 0);
            if (i == 5) chk("af_rise", s_af, 1);
        end
        chk("fill_full", s_full, 1);
        step(1, 8'h99, 0, 1);
        chk("ovf_pulse", s_ovf, 1);
        chk("ovf_count", s_count, 8);
        step(0, 8'h00, 0, 1);
        chk("ovf_clear", s_ovf, 0);

        // Drain in standard mode plus one extra read
        for (int i = 0; i < 9; i++) begin
            step(0, 8'h00, 1, 1);
            if (i < 8) begin
                chk("drain_data", s_data, 8'h10 + i);
                chk("drain_valid", s_valid, 1);
            end else begin
                chk("udf_pulse", s_udf, 1);
                chk("udf_hold", s_data, 8'h17);
                chk("udf_valid", s_valid, 0);
                chk("udf_empty", s_empty, 1);
            end
        end

        // Simultaneous write/read on empty: write wins, read rejected
        step(1, 8'h20, 1, 1);
        chk("sim_e_udf", s_udf, 1);
        chk("sim_e_count", s_count, 1);
        chk("sim_e_fdata", f_data, 8'h20);
        for (int i = 1; i < 8; i++) step(1, W'(8'h20 + i), 0, 1);
        chk("refill_full", s_full, 1);

        // Simultaneous write/read on full: both accepted
        step(1, 8'h28, 1, 1);
        chk("sim_f_count", s_count, 8);
        chk("sim_f_ovf", s_ovf, 0);
        chk("sim_f_data", s_data, 8'h20);

        // Down to count 3, then concurrent streaming across pointer wrap
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 1);
        chk("pre_wrap_count", s_count, 3);
        for (int i = 0; i < 20; i++) begin
            step(1, W'(8'h40 + i), 1, 1);
            chk("wrap_count", s_count, 3);
            if (i == 3) chk("wrap_first", s_data, 8'h40);
        end
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1);
        chk("wrap_last", s_data, 8'h53);
        chk("wrap_empty", s_empty, 1);

        // FWFT: word visible without a read, then popped
        step(1, 8'hA5, 0, 1);
        chk("fwft_data", f_data, 8'hA5);
        chk("fwft_valid", f_valid, 1);
        step(0, 8'h00, 0, 1);
        chk("fwft_hold", f_data, 8'hA5);
        step(0, 8'h00, 1, 1);
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_valid", f_valid, 0);

        // Mid-operation reset at count 5 with a pending write
        for (int i = 0; i < 5; i++) step(1, W'(8'h60 + i), 0, 1);
        chk("pre_rst_count", s_count, 5);
        step(1, 8'h77, 0, 0);
        chk("mid_rst_count", s_count, 0);
        chk("mid_rst_empty", s_empty, 1);
        chk("mid_rst_data", s_data, 0);
        chk("mid_rst_ovf", s_ovf, 0);
        chk("mid_rst_udf", s_udf, 0);
        chk("mid_rst_fvalid", f_valid, 0);

        // Recovery after reset
        step(1, 8'h88, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("recover_data", s_data, 8'h88);
        step(0, 8'h00, 0, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Single-clock, parametrised synchronous FIFO; successor to the team's basic pointer-compare FIFO.
- Adds:
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - standard or first-word-fall-through (FWFT) read mode
  - overflow/underflow error pulses
  - defined read-data behaviour (never X)
- Sits between producer/consumer stages in the same clock domain as a general buffering primitive.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- wr_en  input  1  write request.
- data_in  input  WIDTH  write data.
- rd_en  input  1  read request (FWFT: pop/acknowledge of head word).
- data_out  output  WIDTH  read data.
- rd_valid  output  1  data_out holds a valid word (see Behaviour).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-low (rst_n).
  - Reset clears pointers and count to 0, data_out to 0, and rd_valid, overflow, underflow to 0.
  - After reset: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0).
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data on that edge. Any wr_en/rd_en in that cycle is ignored and raises no error pulse.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - A separate count register tracks occupancy. All flags decode combinationally from the count register; no pointer-MSB compare is used.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous accepted read frees the slot.
  - When empty, a simultaneous write is accepted and the read is rejected. This holds in both modes: no write-to-read bypass.
- count update:
  - +1 if wr_acc && !rd_acc.
  - -1 if rd_acc && !wr_acc.
  - Unchanged if both or neither.
- Error pulses:
  - overflow = registered (wr_en && !wr_acc).
  - underflow = registered (rd_en && !rd_acc).
  - Each is high for exactly the cycle after the rejected request.
  - Rejected requests change no state.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge, and rd_valid is high for the following cycle only. Read latency is 1 cycle.
  - Otherwise data_out holds its last value and rd_valid=0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the displayed word; the next word appears on data_out after that edge.
  - A word written into an empty FIFO appears on data_out one cycle after its write edge.
- Write path: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments.
- Thresholds: almost_full and almost_empty are combinational from count and may be asserted together when DEPTH is small.
- Elaboration: WIDTH, DEPTH, FWFT, AF_LEVEL and AE_LEVEL are checked at elaboration; illegal values stop elaboration with an error.

Test Plan:
- Reset and fill (DEPTH=8, WIDTH=8, FWFT=0):
  - After reset, write 8 words 0x10..0x17 on consecutive cycles -> count steps 0..8.
  - almost_full rises at count=6; full=1 after the 8th write.
  - A 9th write -> overflow=1 for one cycle, count stays 8.
- Drain, standard mode: from full, assert rd_en for 9 cycles.
  - data_out = 0x10..0x17, each with rd_valid one cycle after its rd_en.
  - empty=1 after the 8th read; 9th read -> underflow pulse, data_out holds 0x17.
- Simultaneous ops:
  - When full, wr_en+rd_en -> both accepted, count stays 8, no overflow.
  - When empty, wr_en+rd_en -> write accepted, underflow=1, count=1.
- Wrap-around: run 20 cycles of concurrent write/read at count=3 with an incrementing pattern.
  - Output sequence matches input with no gaps or duplicates across pointer wrap.
  - count constant at 3.
- FWFT=1:
  - Write 0xA5 into empty FIFO -> data_out=0xA5, rd_valid=1 on the next cycle with no rd_en.
  - rd_en pops it -> empty=1, rd_valid=0 the following cycle.
- Mid-operation reset: at count=5, pull rst_n low for one edge while wr_en=1.
  - Next cycle: count=0, empty=1, data_out=0, no overflow/underflow pulse.
